// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory-port arbiter.
//   state_e  - arbiter FSM states
//   grant_e  - grant history encoding (no grant yet / fetch / data)
//   LB..SW   - RV32I load/store funct3 encodings
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        GntNone,
        GntFetch,
        GntData
    } grant_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/mem_arbiter_align_check.sv
// align_check: combinational legality check for one memory request.
//   funct3   in  3  load/store funct3 (fetches present LW)
//   addr     in  2  low byte-address bits
//   we       in  1  1 = store
//   is_fetch in  1  request comes from instruction fetch
//   fault    out 1  misaligned access or illegal funct3
module align_check
    import mem_arb_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr,
    input  logic       we,
    input  logic       is_fetch,
    output logic       fault
);

    always_comb begin
        fault = 1'b0;
        if (is_fetch) begin
            fault = (addr != 2'b00);
        end else begin
            case (funct3)
                // Unsigned variants have no store counterpart.
                LB, LBU: fault = we && funct3[2];
                LH, LHU: fault = addr[0] || (we && funct3[2]);
                LW:      fault = (addr != 2'b00);
                default: fault = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port arbiter between instruction fetch and load/store
// in front of a memory with one-cycle synchronous read latency.
//   clk, reset            clock, synchronous active-high reset
//   if_req/if_addr        fetch request (level, held until if_done)
//   if_done/if_rdata/if_fault   fetch completion pulse, word, misalign flag
//   ls_req/ls_we/ls_funct3/ls_addr/ls_wdata   load/store request
//   ls_done/ls_rdata/ls_fault   load/store completion pulse, data, fault flag
//   mem_*                 memory-side address, funct3, write strobe and data
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    output logic        if_fault,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        ls_fault,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data
);

    state_e      r_state,      w_state_d;
    grant_e      r_last,       w_last_d;
    logic        r_gnt_data,   w_gnt_data_d;
    logic        r_mem_write,  w_mem_write_d;
    logic [2:0]  r_mem_funct3, w_mem_funct3_d;
    logic [31:0] r_wr_addr,    w_wr_addr_d;
    logic [31:0] r_wr_data,    w_wr_data_d;
    logic [31:0] r_rd_addr,    w_rd_addr_d;
    logic [31:0] r_if_rdata,   w_if_rdata_d;
    logic [31:0] r_ls_rdata,   w_ls_rdata_d;
    logic        r_if_done,    w_if_done_d;
    logic        r_ls_done,    w_ls_done_d;
    logic        r_if_fault,   w_if_fault_d;
    logic        r_ls_fault,   w_ls_fault_d;

    logic        w_pick_data;
    logic        w_fault;

    // Data wins when alone, when fetch went last, or on the very first contest.
    assign w_pick_data = ls_req &&
                         (!if_req || (r_last == GntFetch) || ((r_last == GntNone) && DATA_FIRST));

    align_check u_align_check (
        .funct3   (w_pick_data ? ls_funct3 : LW),
        .addr     (w_pick_data ? ls_addr[1:0] : if_addr[1:0]),
        .we       (w_pick_data && ls_we),
        .is_fetch (!w_pick_data),
        .fault    (w_fault)
    );

    always_comb begin
        w_state_d      = r_state;
        w_last_d       = r_last;
        w_gnt_data_d   = r_gnt_data;
        w_mem_write_d  = 1'b0;
        w_mem_funct3_d = r_mem_funct3;
        w_wr_addr_d    = r_wr_addr;
        w_wr_data_d    = r_wr_data;
        w_rd_addr_d    = r_rd_addr;
        w_if_rdata_d   = r_if_rdata;
        w_ls_rdata_d   = r_ls_rdata;
        w_if_done_d    = 1'b0;
        w_ls_done_d    = 1'b0;
        w_if_fault_d   = 1'b0;
        w_ls_fault_d   = 1'b0;

        case (r_state)
            StIdle: begin
                if (if_req || ls_req) begin
                    w_gnt_data_d = w_pick_data;
                    w_last_d     = w_pick_data ? GntData : GntFetch;
                    if (w_fault) begin
                        // Fault: respond without touching any memory-side register.
                        w_state_d = StResp;
                        if (w_pick_data) begin
                            w_ls_done_d  = 1'b1;
                            w_ls_fault_d = 1'b1;
                            w_ls_rdata_d = '0;
                        end else begin
                            w_if_done_d  = 1'b1;
                            w_if_fault_d = 1'b1;
                            w_if_rdata_d = '0;
                        end
                    end else if (w_pick_data && ls_we) begin
                        w_state_d      = StResp;
                        w_mem_write_d  = 1'b1;
                        w_mem_funct3_d = ls_funct3;
                        w_wr_addr_d    = ls_addr;
                        w_wr_data_d    = ls_wdata;
                        w_ls_done_d    = 1'b1;
                        w_ls_rdata_d   = '0;
                    end else begin
                        w_state_d      = StRdAddr;
                        w_rd_addr_d    = w_pick_data ? ls_addr : if_addr;
                        w_mem_funct3_d = w_pick_data ? ls_funct3 : LW;
                    end
                end
            end
            StRdAddr: w_state_d = StRdData;
            StRdData: begin
                // Address and funct3 still held, so read_data is the formatted word.
                w_state_d = StResp;
                if (r_gnt_data) begin
                    w_ls_rdata_d = mem_read_data;
                    w_ls_done_d  = 1'b1;
                end else begin
                    w_if_rdata_d = mem_read_data;
                    w_if_done_d  = 1'b1;
                end
            end
            StResp:   w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_last       <= GntNone;
            r_gnt_data   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_funct3 <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_rd_addr    <= '0;
            r_if_rdata   <= '0;
            r_ls_rdata   <= '0;
            r_if_done    <= 1'b0;
            r_ls_done    <= 1'b0;
            r_if_fault   <= 1'b0;
            r_ls_fault   <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_last       <= w_last_d;
            r_gnt_data   <= w_gnt_data_d;
            r_mem_write  <= w_mem_write_d;
            r_mem_funct3 <= w_mem_funct3_d;
            r_wr_addr    <= w_wr_addr_d;
            r_wr_data    <= w_wr_data_d;
            r_rd_addr    <= w_rd_addr_d;
            r_if_rdata   <= w_if_rdata_d;
            r_ls_rdata   <= w_ls_rdata_d;
            r_if_done    <= w_if_done_d;
            r_ls_done    <= w_ls_done_d;
            r_if_fault   <= w_if_fault_d;
            r_ls_fault   <= w_ls_fault_d;
        end
    end

    // Reset in a RESP cycle must suppress the write and the completion at once.
    assign mem_write         = r_mem_write & ~reset;
    assign if_done           = r_if_done & ~reset;
    assign ls_done           = r_ls_done & ~reset;
    assign mem_funct3        = r_mem_funct3;
    assign mem_write_address = r_wr_addr;
    assign mem_write_data    = r_wr_data;
    assign mem_read_address  = r_rd_addr;
    assign if_rdata          = r_if_rdata;
    assign ls_rdata          = r_ls_rdata;
    assign if_fault          = r_if_fault;
    assign ls_fault          = r_ls_fault;

endmodule
